convolution_2d: RTL and testbench

- Event-driven 2D spiking convolution layer.
- Accepts one input event at a time: timestep, (x,y) and a per-input-channel spike mask.
- For every in-bounds neighbour in the KERNEL_SIZE×KERNEL_SIZE window it reads the packed OUT_CHANNELS membrane potentials through the arbiter, adds the kernel weights of all spiking input channels, and writes the result back.
- Sits between the event source, the kernel weight BRAM and the membrane-memory arbiter (conv read/write ports).

---
 rtl/convolution_2d.sv | 258 +++++++++++++++++++++++++
 tb/tb_convolution_2d.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/convolution_2d.sv
// ---------------------------------------------------------------------------
// convolution_2d
// Event-driven 2D spiking convolution layer.
//
// For each accepted event (x, y, spike mask), the block walks the
// KERNEL_SIZE x KERNEL_SIZE window in raster order. For every in-bounds
// neighbour it does four things:
//   1. reads the kernel weight word,
//   2. reads the packed membrane potentials through the arbiter,
//   3. adds the weights of every spiking input channel, saturating the result,
//   4. writes the updated potentials back.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   event_*           incoming event (timestep ignored), valid / ack handshake
//   kernel_*          kernel weight BRAM port (1-cycle read latency, never written)
//   rd_*              membrane read port (request held until rd_valid)
//   wr_*              membrane write port (single-cycle strobe, always accepted)
// ---------------------------------------------------------------------------
module convolution_2d #(
    parameter int IN_CHANNELS      = 2,
    parameter int OUT_CHANNELS     = 2,
    parameter int KERNEL_SIZE      = 3,
    parameter int BITS_PER_CHANNEL = 6,
    parameter int COORD_BITS       = 8,
    parameter int IMG_WIDTH        = 8,
    parameter int IMG_HEIGHT       = 8
) (
    input  logic                                                 clk,
    input  logic                                                 rst_n,
    input  logic [COORD_BITS-1:0]                                event_timestep,
    input  logic [COORD_BITS-1:0]                                event_x,
    input  logic [COORD_BITS-1:0]                                event_y,
    input  logic [IN_CHANNELS-1:0]                               event_spikes,
    input  logic                                                 event_valid,
    output logic                                                 event_ack,
    output logic [$clog2(KERNEL_SIZE*KERNEL_SIZE)-1:0]           kernel_addr,
    output logic                                                 kernel_en,
    output logic                                                 kernel_we,
    input  logic [IN_CHANNELS*OUT_CHANNELS*BITS_PER_CHANNEL-1:0] kernel_data,
    output logic                                                 rd_req,
    output logic [COORD_BITS-1:0]                                rd_x,
    output logic [COORD_BITS-1:0]                                rd_y,
    input  logic [OUT_CHANNELS*BITS_PER_CHANNEL-1:0]             rd_data,
    input  logic                                                 rd_valid,
    output logic                                                 wr_req,
    output logic [COORD_BITS-1:0]                                wr_x,
    output logic [COORD_BITS-1:0]                                wr_y,
    output logic [OUT_CHANNELS*BITS_PER_CHANNEL-1:0]             wr_data
);

    localparam int BPC   = BITS_PER_CHANNEL;
    localparam int KA_W  = $clog2(KERNEL_SIZE*KERNEL_SIZE);
    localparam int KI_W  = (KERNEL_SIZE > 1) ? $clog2(KERNEL_SIZE) : 1;
    localparam int ST_W  = COORD_BITS + 2;
    localparam int ACC_W = BPC + $clog2(IN_CHANNELS + 1) + 1;
    localparam int KW_W  = IN_CHANNELS*OUT_CHANNELS*BPC;
    localparam int PW_W  = OUT_CHANNELS*BPC;

    localparam logic signed [ST_W-1:0]  HALF = ST_W'(KERNEL_SIZE/2);
    localparam logic signed [ST_W-1:0]  XMAX = ST_W'(IMG_WIDTH-1);
    localparam logic signed [ST_W-1:0]  YMAX = ST_W'(IMG_HEIGHT-1);
    localparam logic signed [ACC_W-1:0] SMAX = ACC_W'((1 <<< (BPC-1)) - 1);
    localparam logic signed [ACC_W-1:0] SMIN = ACC_W'(-(1 <<< (BPC-1)));
    localparam logic [KI_W-1:0]         KLAST = KI_W'(KERNEL_SIZE-1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_KREAD,
        S_KWAIT,
        S_MREQ,
        S_ACCUM,
        S_WRITE,
        S_NEXT
    } state_t;

    // Clamp a wide sum back into the signed BPC-bit potential range.
    function automatic logic [BPC-1:0] sat(input logic signed [ACC_W-1:0] v);
        if (v > SMAX) begin
            return SMAX[BPC-1:0];
        end else if (v < SMIN) begin
            return SMIN[BPC-1:0];
        end else begin
            return v[BPC-1:0];
        end
    endfunction

    state_t                  r_state;
    logic [COORD_BITS-1:0]   r_ex;
    logic [COORD_BITS-1:0]   r_ey;
    logic [IN_CHANNELS-1:0]  r_spikes;
    logic [KI_W-1:0]         r_kx;
    logic [KI_W-1:0]         r_ky;
    logic [COORD_BITS-1:0]   r_tx;
    logic [COORD_BITS-1:0]   r_ty;
    logic [KW_W-1:0]         r_weights;
    logic                    r_kw_pend;
    logic [PW_W-1:0]         r_pot;
    logic                    r_event_ack;
    logic [KA_W-1:0]         r_kernel_addr;
    logic                    r_kernel_en;
    logic                    r_rd_req;
    logic [COORD_BITS-1:0]   r_rd_x;
    logic [COORD_BITS-1:0]   r_rd_y;
    logic                    r_wr_req;
    logic [COORD_BITS-1:0]   r_wr_x;
    logic [COORD_BITS-1:0]   r_wr_y;
    logic [PW_W-1:0]         r_wr_data;

    logic signed [ST_W-1:0]  w_tx;
    logic signed [ST_W-1:0]  w_ty;
    logic                    w_in_bounds;
    logic [PW_W-1:0]         w_new;
    logic                    w_unused;

    assign w_unused = ^event_timestep;

    // Target pixel of the current kernel tap; signed so that taps falling
    // off the left/top edge come out negative rather than wrapping.
    assign w_tx = $signed({2'b00, r_ex}) + $signed({{(ST_W-KI_W){1'b0}}, r_kx}) - HALF;
    assign w_ty = $signed({2'b00, r_ey}) + $signed({{(ST_W-KI_W){1'b0}}, r_ky}) - HALF;
    assign w_in_bounds = !w_tx[ST_W-1] && (w_tx <= XMAX) &&
                         !w_ty[ST_W-1] && (w_ty <= YMAX);

    // Per output channel: potential plus the weights of every spiking input.
    always_comb begin
        logic signed [ACC_W-1:0] acc;
        w_new = '0;
        acc   = '0;
        for (int o = 0; o < OUT_CHANNELS; o++) begin
            acc = ACC_W'($signed(r_pot[o*BPC +: BPC]));
            for (int i = 0; i < IN_CHANNELS; i++) begin
                if (r_spikes[i]) begin
                    acc = acc + ACC_W'($signed(r_weights[(i*OUT_CHANNELS+o)*BPC +: BPC]));
                end
            end
            w_new[o*BPC +: BPC] = sat(acc);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_ex          <= '0;
            r_ey          <= '0;
            r_spikes      <= '0;
            r_kx          <= '0;
            r_ky          <= '0;
            r_tx          <= '0;
            r_ty          <= '0;
            r_weights     <= '0;
            r_kw_pend     <= 1'b0;
            r_pot         <= '0;
            r_event_ack   <= 1'b0;
            r_kernel_addr <= '0;
            r_kernel_en   <= 1'b0;
            r_rd_req      <= 1'b0;
            r_rd_x        <= '0;
            r_rd_y        <= '0;
            r_wr_req      <= 1'b0;
            r_wr_x        <= '0;
            r_wr_y        <= '0;
            r_wr_data     <= '0;
        end else begin
            r_event_ack <= 1'b0;
            r_kernel_en <= 1'b0;
            r_wr_req    <= 1'b0;
            case (r_state)
                // The ack register blocks a re-accept while the source is
                // still seeing the ack and has not yet dropped valid.
                S_IDLE: begin
                    if (event_valid && !r_event_ack) begin
                        r_ex        <= event_x;
                        r_ey        <= event_y;
                        r_spikes    <= event_spikes;
                        r_kx        <= '0;
                        r_ky        <= '0;
                        r_event_ack <= 1'b1;
                        if (event_spikes != '0) begin
                            r_state <= S_KREAD;
                        end
                    end
                end
                S_KREAD: begin
                    r_tx <= w_tx[COORD_BITS-1:0];
                    r_ty <= w_ty[COORD_BITS-1:0];
                    if (w_in_bounds) begin
                        r_kernel_addr <= KA_W'(int'(r_ky) * KERNEL_SIZE + int'(r_kx));
                        r_kernel_en   <= 1'b1;
                        r_state       <= S_KWAIT;
                    end else begin
                        r_state <= S_NEXT;
                    end
                end
                S_KWAIT: begin
                    r_rd_req  <= 1'b1;
                    r_rd_x    <= r_tx;
                    r_rd_y    <= r_ty;
                    r_kw_pend <= 1'b1;
                    r_state   <= S_MREQ;
                end
                // Kernel data is valid on the first MREQ cycle; it is captured
                // then, independently of when the potentials arrive.
                S_MREQ: begin
                    if (r_kw_pend) begin
                        r_weights <= kernel_data;
                        r_kw_pend <= 1'b0;
                    end
                    if (rd_valid) begin
                        r_pot    <= rd_data;
                        r_rd_req <= 1'b0;
                        r_state  <= S_ACCUM;
                    end
                end
                S_ACCUM: begin
                    r_wr_data <= w_new;
                    r_wr_x    <= r_tx;
                    r_wr_y    <= r_ty;
                    r_wr_req  <= 1'b1;
                    r_state   <= S_WRITE;
                end
                S_WRITE: begin
                    r_state <= S_NEXT;
                end
                S_NEXT: begin
                    if (r_kx == KLAST) begin
                        r_kx <= '0;
                        if (r_ky == KLAST) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_ky    <= r_ky + 1'b1;
                            r_state <= S_KREAD;
                        end
                    end else begin
                        r_kx    <= r_kx + 1'b1;
                        r_state <= S_KREAD;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign event_ack   = r_event_ack;
    assign kernel_addr = r_kernel_addr;
    assign kernel_en   = r_kernel_en;
    assign kernel_we   = 1'b0;
    assign rd_req      = r_rd_req;
    assign rd_x        = r_rd_x;
    assign rd_y        = r_rd_y;
    assign wr_req      = r_wr_req;
    assign wr_x        = r_wr_x;
    assign wr_y        = r_wr_y;
    assign wr_data     = r_wr_data;

endmodule

// File: tb/tb_convolution_2d.sv
// ---------------------------------------------------------------------------
// tb_convolution_2d
// Scoreboard bench for convolution_2d. Models the kernel BRAM and the
// membrane memory/arbiter, queues the expected writes for every event and
// checks them in a monitor on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_convolution_2d;

    localparam int IN_CH  = 2;
    localparam int OUT_CH = 2;
    localparam int K      = 3;
    localparam int BPC    = 6;
    localparam int CB     = 8;

    logic                        clk;
    logic                        rst_n;
    logic [CB-1:0]               event_timestep;
    logic [CB-1:0]               event_x;
    logic [CB-1:0]               event_y;
    logic [IN_CH-1:0]            event_spikes;
    logic                        event_valid;
    logic                        event_ack;
    logic [3:0]                  kernel_addr;
    logic                        kernel_en;
    logic                        kernel_we;
    logic [IN_CH*OUT_CH*BPC-1:0] kernel_data;
    logic                        rd_req;
    logic [CB-1:0]               rd_x;
    logic [CB-1:0]               rd_y;
    logic [OUT_CH*BPC-1:0]       rd_data;
    logic                        rd_valid;
    logic                        wr_req;
    logic [CB-1:0]               wr_x;
    logic [CB-1:0]               wr_y;
    logic [OUT_CH*BPC-1:0]       wr_data;

    convolution_2d #(
        .IN_CHANNELS(IN_CH), .OUT_CHANNELS(OUT_CH), .KERNEL_SIZE(K),
        .BITS_PER_CHANNEL(BPC), .COORD_BITS(CB), .IMG_WIDTH(8), .IMG_HEIGHT(8)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .event_timestep(event_timestep), .event_x(event_x), .event_y(event_y),
        .event_spikes(event_spikes), .event_valid(event_valid), .event_ack(event_ack),
        .kernel_addr(kernel_addr), .kernel_en(kernel_en), .kernel_we(kernel_we),
        .kernel_data(kernel_data),
        .rd_req(rd_req), .rd_x(rd_x), .rd_y(rd_y), .rd_data(rd_data), .rd_valid(rd_valid),
        .wr_req(wr_req), .wr_x(wr_x), .wr_y(wr_y), .wr_data(wr_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int ack_cnt  = 0;
    int rd_cnt   = 0;
    int wr_cnt   = 0;

    typedef struct {
        logic [7:0]  x;
        logic [7:0]  y;
        logic [11:0] d;
        logic [3:0]  ka;
    } exp_t;
    exp_t sbq[$];

    // Memory / kernel models
    logic [11:0] mem [64];
    logic [23:0] w_all;
    logic        do_clear;
    logic        do_pre;
    logic [5:0]  pre_addr;
    logic [11:0] pre_val;

    always @(posedge clk) begin
        if (do_clear) begin
            for (int i = 0; i < 64; i++) mem[i] <= '0;
        end
        if (do_pre) mem[pre_addr] <= pre_val;
        if (wr_req) mem[{wr_y[2:0], wr_x[2:0]}] <= wr_data;
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            rd_valid <= rd_req && !rd_valid;
            if (rd_req) rd_data <= mem[{rd_y[2:0], rd_x[2:0]}];
        end
    end

    always @(posedge clk) begin
        if (kernel_en) kernel_data <= w_all;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor
    logic       rd_req_q = 1'b0;
    logic [3:0] last_ka  = '0;
    always @(negedge clk) begin
        if (!rst_n) begin
            rd_req_q = 1'b0;
        end else begin
            if (event_ack) ack_cnt++;
            if (kernel_en) last_ka = kernel_addr;
            if (rd_req && !rd_req_q) begin
                rd_cnt++;
                chk("rd_in_range", 32'(rd_x < 8 && rd_y < 8), 32'd1);
            end
            if (wr_req) begin
                wr_cnt++;
                chk("rd_wr_exclusive", 32'(rd_req), 32'd0);
                if (sbq.size() == 0) begin
                    chk("unexpected_write", {wr_x, wr_y, wr_data, last_ka}, 32'd0);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    chk("write_x_y_data_kaddr", {wr_x, wr_y, wr_data, last_ka},
                        {e.x, e.y, e.d, e.ka});
                end
            end
            rd_req_q = rd_req;
        end
    end

    task automatic push(input int x, input int y, input logic [11:0] d, input int ka);
        exp_t e;
        e.x = 8'(x); e.y = 8'(y); e.d = d; e.ka = 4'(ka);
        sbq.push_back(e);
    endtask

    // Full interior window around (ex,ey), same data at every tap except
    // optionally a distinct value at the centre.
    task automatic push_win(input int ex, input int ey, input logic [11:0] d,
                            input logic [11:0] dc);
        for (int ky = 0; ky < K; ky++)
            for (int kx = 0; kx < K; kx++)
                push(ex+kx-1, ey+ky-1, (kx == 1 && ky == 1) ? dc : d, ky*K+kx);
    endtask

    task automatic clear_mem();
        do_clear = 1'b1;
        @(posedge clk); #1;
        do_clear = 1'b0;
    endtask

    task automatic preload(input logic [5:0] a, input logic [11:0] v);
        pre_addr = a; pre_val = v; do_pre = 1'b1;
        @(posedge clk); #1;
        do_pre = 1'b0;
    endtask

    task automatic send_event(input int x, input int y, input logic [1:0] sp);
        bit got;
        got = 1'b0;
        event_x = 8'(x); event_y = 8'(y); event_spikes = sp; event_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (event_ack) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) chk("ack_timeout", 32'd0, 32'd1);
        event_valid = 1'b0;
    endtask

    task automatic wait_done(input string name);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (sbq.size() == 0) begin
                done = 1'b1;
                break;
            end
        end
        repeat (4) @(negedge clk);
        chk(name, 32'(done), 32'd1);
    endtask

    int a0, r0, w0, w_at_ack;

    initial begin
        rst_n = 1'b0; event_timestep = '0; event_x = '0; event_y = '0;
        event_spikes = '0; event_valid = 1'b0;
        do_clear = 1'b0; do_pre = 1'b0; pre_addr = '0; pre_val = '0;
        w_all = {4{6'd1}};
        clear_mem();
        repeat (2) @(posedge clk); #1;
        chk("reset_outputs", {event_ack, kernel_en, kernel_we, rd_req, wr_req, kernel_addr,
                              wr_data}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Interior event, both channels spiking, weights +1
        a0 = ack_cnt; w0 = wr_cnt;
        push_win(5, 3, 12'h082, 12'h082);
        send_event(5, 3, 2'b11);
        wait_done("t1_done");
        chk("t1_acks", 32'(ack_cnt - a0), 32'd1);
        chk("t1_writes", 32'(wr_cnt - w0), 32'd9);
        chk("t1_mem_centre", 32'(mem[{3'd3, 3'd5}]), 32'h082);
        chk("t1_mem_untouched_0_0", 32'(mem[0]), 32'd0);
        chk("t1_mem_untouched_7_5", 32'(mem[{3'd5, 3'd7}]), 32'd0);

        // Corner event: only four taps in bounds
        @(posedge clk); #1;
        clear_mem();
        r0 = rd_cnt; w0 = wr_cnt;
        push(0, 0, 12'h041, 4); push(1, 0, 12'h041, 5);
        push(0, 1, 12'h041, 7); push(1, 1, 12'h041, 8);
        send_event(0, 0, 2'b01);
        wait_done("t2_done");
        chk("t2_writes", 32'(wr_cnt - w0), 32'd4);
        chk("t2_reads", 32'(rd_cnt - r0), 32'd4);

        // Empty spike mask: ack only, no traffic
        @(posedge clk); #1;
        a0 = ack_cnt; r0 = rd_cnt; w0 = wr_cnt;
        send_event(7, 7, 2'b00);
        repeat (10) @(negedge clk);
        chk("t3_acks", 32'(ack_cnt - a0), 32'd1);
        chk("t3_reads", 32'(rd_cnt - r0), 32'd0);
        chk("t3_writes", 32'(wr_cnt - w0), 32'd0);

        // Positive saturation at the centre pixel
        @(posedge clk); #1;
        clear_mem();
        preload({3'd3, 3'd5}, 12'h79E);
        push_win(5, 3, 12'h082, 12'h7DF);
        send_event(5, 3, 2'b11);
        wait_done("t4_done");
        chk("t4_mem_centre", 32'(mem[{3'd3, 3'd5}]), 32'h7DF);

        // Negative saturation: weights -20, centre preload -30
        @(posedge clk); #1;
        clear_mem();
        preload({3'd3, 3'd5}, 12'h8A2);
        w_all = {4{6'd44}};
        push_win(5, 3, 12'h820, 12'h820);
        send_event(5, 3, 2'b11);
        wait_done("t5_done");
        w_all = {4{6'd1}};

        // Reset during the third tap's memory request
        @(posedge clk); #1;
        clear_mem();
        w0 = wr_cnt;
        push(4, 2, 12'h082, 0); push(5, 2, 12'h082, 1);
        send_event(5, 3, 2'b11);
        begin
            bit hit;
            hit = 1'b0;
            for (int i = 0; i < 200; i++) begin
                @(negedge clk);
                if (rd_req && rd_x == 8'd6 && rd_y == 8'd2) begin
                    hit = 1'b1;
                    break;
                end
            end
            chk("t6_reached_third_tap", 32'(hit), 32'd1);
        end
        #2 rst_n = 1'b0;
        #1 chk("t6_outputs_in_reset", {event_ack, kernel_en, rd_req, wr_req, wr_data}, 32'd0);
        repeat (3) @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("t6_writes_before_reset", 32'(wr_cnt - w0), 32'd2);
        chk("t6_queue_drained", 32'(sbq.size()), 32'd0);
        @(posedge clk); #1;
        push(4, 2, 12'h104, 0); push(5, 2, 12'h104, 1); push(6, 2, 12'h082, 2);
        push(4, 3, 12'h082, 3); push(5, 3, 12'h082, 4); push(6, 3, 12'h082, 5);
        push(4, 4, 12'h082, 6); push(5, 4, 12'h082, 7); push(6, 4, 12'h082, 8);
        send_event(5, 3, 2'b11);
        wait_done("t6_done");

        // Back-to-back events with overlapping windows
        @(posedge clk); #1;
        clear_mem();
        w0 = wr_cnt;
        push_win(5, 3, 12'h082, 12'h082);
        push(4, 3, 12'h104, 0); push(5, 3, 12'h104, 1); push(6, 3, 12'h104, 2);
        push(4, 4, 12'h104, 3); push(5, 4, 12'h104, 4); push(6, 4, 12'h104, 5);
        push(4, 5, 12'h082, 6); push(5, 5, 12'h082, 7); push(6, 5, 12'h082, 8);
        send_event(5, 3, 2'b11);
        @(posedge clk); #1;
        send_event(5, 4, 2'b11);
        w_at_ack = wr_cnt - w0;
        chk("t7_second_ack_after_9_writes", 32'(w_at_ack), 32'd9);
        wait_done("t7_done");
        chk("t7_writes", 32'(wr_cnt - w0), 32'd18);
        chk("t7_mem_overlap_5_4", 32'(mem[{3'd4, 3'd5}]), 32'h104);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
